// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter.
// Drives PS2_CLK/PS2_DAT open-drain through output enables and reports ACK, NACK or timeout.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int REQ_CYCLES     = 250,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] din,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int MAX_A      = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
   localparam int MAX_CYCLES = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_REQ,
      S_BITS,
      S_ACK,
      S_WAIT_IDLE,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic             r_clk_s1;
   logic             r_clk_s2;
   logic             r_dat_s1;
   logic             r_dat_s2;
   logic             r_clk_prev;
   logic [10:0]      r_shift;
   logic [3:0]       r_edge_cnt;
   logic [CNT_W-1:0] r_cnt;
   logic             r_error;

   logic w_fall;
   logic w_load;
   logic w_shift;
   logic w_cnt_clr;
   logic w_err_set;
   logic w_ack_sample;
   logic w_inh_last;
   logic w_req_last;
   logic w_timeout;

   assign w_fall     = r_clk_prev & ~r_clk_s2;
   assign w_inh_last = (r_cnt == CNT_W'(INHIBIT_CYCLES - 1));
   assign w_req_last = (r_cnt == CNT_W'(REQ_CYCLES - 1));
   assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Outputs are decoded from state so the reset state releases both lines.
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_shift      = 1'b0;
      w_cnt_clr    = 1'b0;
      w_err_set    = 1'b0;
      w_ack_sample = 1'b0;
      ps2_clk_oe   = 1'b0;
      ps2_dat_oe   = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      error        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_load       = 1'b1;
               w_cnt_clr    = 1'b1;
               w_state_next = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            busy       = 1'b1;
            ps2_clk_oe = 1'b1;
            if (w_inh_last) begin
               w_cnt_clr    = 1'b1;
               w_state_next = S_REQ;
            end
         end
         S_REQ: begin
            busy       = 1'b1;
            ps2_clk_oe = 1'b1;
            ps2_dat_oe = 1'b1;
            if (w_req_last) begin
               w_cnt_clr    = 1'b1;
               w_state_next = S_BITS;
            end
         end
         S_BITS: begin
            busy       = 1'b1;
            ps2_dat_oe = ~r_shift[0];
            // A falling edge takes priority over a coincident timeout.
            if (w_fall) begin
               w_shift   = 1'b1;
               w_cnt_clr = 1'b1;
               if (r_edge_cnt == 4'd9) begin
                  w_state_next = S_ACK;
               end
            end else if (w_timeout) begin
               w_err_set    = 1'b1;
               w_state_next = S_DONE;
            end
         end
         S_ACK: begin
            busy = 1'b1;
            if (w_fall) begin
               w_ack_sample = 1'b1;
               w_cnt_clr    = 1'b1;
               w_state_next = S_WAIT_IDLE;
            end else if (w_timeout) begin
               w_err_set    = 1'b1;
               w_state_next = S_DONE;
            end
         end
         S_WAIT_IDLE: begin
            busy = 1'b1;
            if (r_clk_s2 && r_dat_s2) begin
               w_state_next = S_DONE;
            end else if (w_timeout) begin
               w_err_set    = 1'b1;
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            busy         = 1'b1;
            done         = 1'b1;
            error        = r_error;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // Synchronizers reset to the idle bus level so no false edge follows reset.
         r_clk_s1   <= 1'b1;
         r_clk_s2   <= 1'b1;
         r_dat_s1   <= 1'b1;
         r_dat_s2   <= 1'b1;
         r_clk_prev <= 1'b1;
         r_shift    <= '0;
         r_edge_cnt <= '0;
         r_cnt      <= '0;
         r_error    <= 1'b0;
      end else begin
         r_clk_s1   <= ps2_clk_in;
         r_clk_s2   <= r_clk_s1;
         r_dat_s1   <= ps2_dat_in;
         r_dat_s2   <= r_dat_s1;
         r_clk_prev <= r_clk_s2;

         // Frame LSB first: start 0, data, odd parity, stop 1.
         if (w_load) begin
            r_shift    <= {1'b1, ~^din, din, 1'b0};
            r_edge_cnt <= '0;
         end else if (w_shift) begin
            r_shift    <= {1'b1, r_shift[10:1]};
            r_edge_cnt <= r_edge_cnt + 4'd1;
         end

         if (w_cnt_clr) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end

         if (w_load) begin
            r_error <= 1'b0;
         end else if (w_err_set) begin
            r_error <= 1'b1;
         end else if (w_ack_sample) begin
            r_error <= r_dat_s2;
         end
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks frames, ACKs or NACKs,
// and the bench checks line values, handshake timing, timeout and reset recovery.
module tb_ps2_host_tx;

   localparam int INH = 10;
   localparam int REQ = 4;
   localparam int TO  = 50;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] din;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;
   logic       ps2_clk_in;
   logic       ps2_dat_in;
   logic       ps2_clk_oe;
   logic       ps2_dat_oe;
   logic       busy;
   logic       done;
   logic       error;

   int checks   = 0;
   int failures = 0;

   // Open-drain bus: either side may pull low, pull-up otherwise.
   assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
   assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

   always #5 clk = ~clk;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .REQ_CYCLES    (REQ),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .din       (din),
      .ps2_clk_in(ps2_clk_in),
      .ps2_dat_in(ps2_dat_in),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_dat_oe(ps2_dat_oe),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   typedef struct {
      logic [7:0] din;
      logic       ack;
      logic [9:0] exp_line;  // bus data after falling edges 1..10, bit 0 = edge 1
      logic       exp_err;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One host transaction against the device model. glitch_edge pulses start with
   // din=0 during that bit; abort_edge applies reset after that falling edge.
   task automatic do_frame(input logic [7:0] d, input logic ack, input int glitch_edge,
                           input int abort_edge, input logic [9:0] exp_line,
                           input logic exp_err, input string tag);
      int n;
      logic [9:0] line;
      line = '0;
      @(negedge clk);
      din   = d;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      din   = 8'hA5;
      check({tag, " busy_after_start"}, busy, 1);
      check({tag, " clk_oe_after_start"}, ps2_clk_oe, 1);
      n = 0;
      while (ps2_clk_oe && n < 1000) begin
         n++;
         @(negedge clk);
      end
      check({tag, " clk_oe_cycles"}, n, INH + REQ);
      check({tag, " start_bit_low"}, ps2_dat_in, 0);
      for (int k = 1; k <= 11; k++) begin
         repeat (6) @(negedge clk);
         if (k == glitch_edge) begin
            din   = 8'h00;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
         if (k == 11) dev_dat = ~ack;
         dev_clk = 1'b0;
         repeat (6) @(negedge clk);
         if (k <= 10) line[k-1] = ps2_dat_in;
         if (k == abort_edge) begin
            reset = 1'b1;
            @(negedge clk);
            check({tag, " abort_clk_oe"}, ps2_clk_oe, 0);
            check({tag, " abort_dat_oe"}, ps2_dat_oe, 0);
            check({tag, " abort_busy"}, busy, 0);
            reset   = 1'b0;
            dev_clk = 1'b1;
            dev_dat = 1'b1;
            return;
         end
         dev_clk = 1'b1;
      end
      dev_dat = 1'b1;
      check({tag, " line_bits"}, line, exp_line);
      n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, " done_seen"}, done, 1);
      check({tag, " error"}, error, exp_err);
      @(negedge clk);
      check({tag, " idle_busy"}, busy, 0);
      check({tag, " idle_done"}, done, 0);
      check({tag, " idle_oe"}, {ps2_clk_oe, ps2_dat_oe}, 0);
   endtask

   initial begin
      int n;
      // Hand-computed: {stop, odd parity, data}
      vecs[0] = '{din: 8'hED, ack: 1'b1, exp_line: 10'h3ED, exp_err: 1'b0};
      vecs[1] = '{din: 8'hF4, ack: 1'b1, exp_line: 10'h2F4, exp_err: 1'b0};
      vecs[2] = '{din: 8'h00, ack: 1'b1, exp_line: 10'h300, exp_err: 1'b0};
      vecs[3] = '{din: 8'hED, ack: 1'b0, exp_line: 10'h3ED, exp_err: 1'b1};

      reset = 1'b1;
      start = 1'b1;
      din   = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_outputs", {ps2_clk_oe, ps2_dat_oe, busy, done, error}, 0);
      end
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("post_reset_idle", {ps2_clk_oe, busy}, 0);

      for (int i = 0; i < 4; i++) begin
         do_frame(vecs[i].din, vecs[i].ack, 0, 0, vecs[i].exp_line, vecs[i].exp_err,
                  $sformatf("vec%0d", i));
      end

      do_frame(8'hFF, 1'b1, 3, 0, 10'h3FF, 1'b0, "start_mid_frame");
      do_frame(8'hFF, 1'b1, 0, 4, 10'h3FF, 1'b0, "reset_after_edge4");
      do_frame(8'hF4, 1'b1, 0, 0, 10'h2F4, 1'b0, "after_reset");

      // No device clocks: timeout counted from BITS entry.
      @(negedge clk);
      din   = 8'h55;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (ps2_clk_oe && n < 1000) begin
         n++;
         @(negedge clk);
      end
      check("timeout clk_oe_cycles", n, INH + REQ);
      n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("timeout latency", n, TO);
      check("timeout error", error, 1);
      check("timeout lines_released", {ps2_clk_oe, ps2_dat_oe}, 0);
      @(negedge clk);
      check("timeout busy_low", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
